// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel tick divider.
package clk_div_pkg;

  localparam logic MODE_PULSE = 1'b0;
  localparam logic MODE_SQ    = 1'b1;
  localparam int   MIN_DIV    = 2;

  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor and mode, tick and square outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int DEFAULT_DIV = 250_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_sync_clr,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_sq,
  output logic             o_tick,
  output logic             o_sq
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             mode_q, mode_d;
  logic             pend_mode_q, pend_mode_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             tc, over, half, apply;

  always_comb begin
    tc           = (cnt_q == div_q - CNT_W'(1));
    over         = (cnt_q >= div_q);
    half         = (cnt_q == (div_q >> 1) - CNT_W'(1));
    cnt_d        = cnt_q;
    div_d        = div_q;
    mode_d       = mode_q;
    pend_div_d   = pend_div_q;
    pend_mode_d  = pend_mode_q;
    pend_valid_d = pend_valid_q;
    tick_d       = 1'b0;
    sq_d         = sq_q;
    apply        = 1'b0;

    if (i_sync_clr) begin
      cnt_d = '0;
      sq_d  = 1'b0;
      apply = pend_valid_q;
    end else if (i_en) begin
      if (over) begin
        // Corrupted counter: recover silently, no tick for the broken period.
        cnt_d = '0;
      end else if (tc) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = 1'b0;
        apply  = pend_valid_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mode_q == MODE_SQ && half) sq_d = 1'b1;
      end
    end

    if (apply) begin
      div_d        = pend_div_q;
      mode_d       = pend_mode_q;
      pend_valid_d = 1'b0;
    end

    // A write landing on the TC cycle is captured after the apply above,
    // so it waits for the following terminal count.
    if (i_wr) begin
      pend_div_d   = i_div;
      pend_mode_d  = i_sq;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      div_q        <= CNT_W'(DEFAULT_DIV);
      mode_q       <= MODE_PULSE;
      pend_div_q   <= CNT_W'(DEFAULT_DIV);
      pend_mode_q  <= MODE_PULSE;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      sq_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      mode_q       <= mode_d;
      pend_div_q   <= pend_div_d;
      pend_mode_q  <= pend_mode_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      sq_q         <= sq_d;
    end
  end

  assign o_tick = tick_q;
  assign o_sq   = sq_q;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable tick generator: config decode, range check and
// error pulse around NUM_CH independent divider channels.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 20,
  parameter  int DEFAULT_DIV = 250_000,
  localparam int CH_W        = clog2_safe(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_sq,
  output logic              o_cfg_err,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_sq
);

  logic              cfg_ok;
  logic [NUM_CH-1:0] wr_sel;
  logic              cfg_err_q, cfg_err_d;

  always_comb begin
    cfg_ok    = (cfg_div >= CNT_W'(MIN_DIV)) && (32'(cfg_ch) < NUM_CH);
    cfg_err_d = cfg_we && !cfg_ok;
    wr_sel    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && cfg_ok && 32'(cfg_ch) == i) wr_sel[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_err_d;
  end

  assign o_cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_en      (i_en),
      .i_sync_clr(i_sync_clr),
      .i_wr      (wr_sel[g]),
      .i_div     (cfg_div),
      .i_sq      (cfg_sq),
      .o_tick    (o_tick[g]),
      .o_sq      (o_sq[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi: directed scenarios plus random traffic against a
// period/position reference model.
module tb_clk_divider_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_en, i_sync_clr;
  logic        cfg_we, cfg_sq;
  logic [1:0]  cfg_ch;
  logic [19:0] cfg_div;
  logic        o_cfg_err;
  logic [3:0]  o_tick, o_sq;

  logic        cfg2_we, cfg2_sq;
  logic [1:0]  cfg2_ch;
  logic [7:0]  cfg2_div;
  logic        o_cfg_err2;
  logic [2:0]  o_tick2, o_sq2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: elapsed enabled edges within the current period, active
  // period/mode and a pending shadow per channel.
  int   m_pos[4], m_n[4], m_pn[4];
  bit   m_mode[4], m_pm[4], m_pv[4];
  logic [3:0] e_tick, e_sq;
  logic       e_err;

  always #5 clk = ~clk;

  clk_divider_multi #(.NUM_CH(4), .CNT_W(20), .DEFAULT_DIV(10)) dut (
    .clk(clk), .reset(reset), .i_en(i_en), .i_sync_clr(i_sync_clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_sq(cfg_sq),
    .o_cfg_err(o_cfg_err), .o_tick(o_tick), .o_sq(o_sq)
  );

  clk_divider_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(6)) dut2 (
    .clk(clk), .reset(reset), .i_en(i_en), .i_sync_clr(i_sync_clr),
    .cfg_we(cfg2_we), .cfg_ch(cfg2_ch), .cfg_div(cfg2_div), .cfg_sq(cfg2_sq),
    .o_cfg_err(o_cfg_err2), .o_tick(o_tick2), .o_sq(o_sq2)
  );

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_pos[c] = 0; m_n[c] = 10; m_mode[c] = 0;
      m_pn[c] = 10; m_pm[c] = 0; m_pv[c] = 0;
    end
    e_tick = '0; e_sq = '0; e_err = 1'b0;
  endtask

  task automatic model_apply(input int c);
    m_n[c] = m_pn[c]; m_mode[c] = m_pm[c]; m_pv[c] = 0;
  endtask

  // Drive one cycle from a negedge, advance the model on the edge, return at the next negedge.
  task automatic step(input bit en, input bit clr, input bit we, input int ch,
                      input int dv, input bit sq);
    bit legal;
    i_en = en; i_sync_clr = clr; cfg_we = we;
    cfg_ch = ch[1:0]; cfg_div = dv[19:0]; cfg_sq = sq;
    legal = (dv >= 2) && (ch >= 0) && (ch < 4);
    @(posedge clk);
    cyc++;
    e_err = we && !legal;
    for (int c = 0; c < 4; c++) begin
      e_tick[c] = 1'b0;
      if (clr) begin
        m_pos[c] = 0; e_sq[c] = 1'b0;
        if (m_pv[c]) model_apply(c);
      end else if (en) begin
        m_pos[c]++;
        if (m_pos[c] == m_n[c]) begin
          e_tick[c] = 1'b1; m_pos[c] = 0;
          if (m_pv[c]) model_apply(c);
        end
        // High during the second half of the period: positions floor(N/2)..N-1.
        e_sq[c] = m_mode[c] && (m_pos[c] >= m_n[c] / 2);
      end
      if (we && legal && ch == c) begin
        m_pn[c] = dv; m_pm[c] = sq; m_pv[c] = 1;
      end
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    i_en = 0; i_sync_clr = 0; cfg_we = 0; cfg_ch = 0; cfg_div = 0; cfg_sq = 0;
    cfg2_we = 0; cfg2_ch = 0; cfg2_div = 0; cfg2_sq = 0;
    reset = 0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (o_tick !== 4'b0 || o_sq !== 4'b0 || o_cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs tick=%b sq=%b err=%b required all 0", o_tick, o_sq, o_cfg_err);
      end
    end
    reset = 1;
  endtask

  task automatic test_default_ticks();
    int first = -1;
    for (int k = 1; k <= 35; k++) begin
      step(1, 0, 0, 0, 0, 0);
      if (first < 0 && o_tick[0]) first = k;
      checks++;
      if (o_tick !== e_tick || o_sq !== e_sq) begin
        errors++;
        $display("FAIL default_ticks k=%0d tick=%b sq=%b required tick=%b sq=%b", k, o_tick, o_sq, e_tick, e_sq);
      end
    end
    checks++;
    if (first !== 10) begin
      errors++;
      $display("FAIL first_tick edge=%0d required 10", first);
    end
  endtask

  task automatic test_reconfig();
    int t_prev = -1, t_last = -1;
    step(1, 0, 1, 1, 5, 1);
    for (int k = 0; k < 40; k++) begin
      step(1, 0, 0, 0, 0, 0);
      if (o_tick[1]) begin t_prev = t_last; t_last = cyc; end
      checks++;
      if (o_tick !== e_tick || o_sq !== e_sq || o_cfg_err !== e_err) begin
        errors++;
        $display("FAIL reconfig k=%0d tick=%b sq=%b err=%b required tick=%b sq=%b err=%b",
                 k, o_tick, o_sq, o_cfg_err, e_tick, e_sq, e_err);
      end
    end
    checks++;
    if (t_last - t_prev !== 5) begin
      errors++;
      $display("FAIL reconfig_period got=%0d required 5", t_last - t_prev);
    end
  endtask

  task automatic test_cfg_err();
    cfg2_we = 1; cfg2_ch = 2'd3; cfg2_div = 8'd5; cfg2_sq = 0;
    step(1, 0, 1, 0, 1, 0);
    cfg2_we = 0;
    checks++;
    if (o_cfg_err !== 1'b1 || o_cfg_err2 !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_reject err=%b err2=%b required 1 1", o_cfg_err, o_cfg_err2);
    end
    cfg2_we = 1; cfg2_ch = 2'd2; cfg2_div = 8'd5;
    step(1, 0, 1, 2, 0, 1);
    cfg2_we = 0;
    checks++;
    if (o_cfg_err !== 1'b1 || o_cfg_err2 !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_second err=%b err2=%b required 1 0", o_cfg_err, o_cfg_err2);
    end
    for (int k = 0; k < 12; k++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (o_tick !== e_tick || o_sq !== e_sq || o_cfg_err !== e_err || o_cfg_err2 !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_after k=%0d tick=%b sq=%b err=%b err2=%b required tick=%b sq=%b err=%b err2=0",
                 k, o_tick, o_sq, o_cfg_err, o_cfg_err2, e_tick, e_sq, e_err);
      end
    end
  endtask

  task automatic test_enable_gap();
    for (int k = 0; k < 30; k++) begin
      step((k < 3 || k >= 10), 0, 0, 0, 0, 0);
      checks++;
      if (o_tick !== e_tick || o_sq !== e_sq) begin
        errors++;
        $display("FAIL enable_gap k=%0d tick=%b sq=%b required tick=%b sq=%b", k, o_tick, o_sq, e_tick, e_sq);
      end
    end
  endtask

  task automatic test_sync_clr();
    int first[4];
    for (int c = 0; c < 4; c++) first[c] = -1;
    step(1, 0, 1, 2, 4, 0);
    step(1, 1, 0, 0, 0, 0);
    checks++;
    if (o_tick !== 4'b0 || o_sq !== 4'b0) begin
      errors++;
      $display("FAIL sync_clr_outputs tick=%b sq=%b required 0 0", o_tick, o_sq);
    end
    for (int k = 1; k <= 12; k++) begin
      step(1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) if (first[c] < 0 && o_tick[c]) first[c] = k;
      checks++;
      if (o_tick !== e_tick || o_sq !== e_sq) begin
        errors++;
        $display("FAIL sync_clr k=%0d tick=%b sq=%b required tick=%b sq=%b", k, o_tick, o_sq, e_tick, e_sq);
      end
    end
    checks++;
    if (first[2] !== 4 || first[0] !== 10 || first[1] !== 5) begin
      errors++;
      $display("FAIL sync_clr_align ch0=%0d ch1=%0d ch2=%0d required 10 5 4", first[0], first[1], first[2]);
    end
  endtask

  task automatic test_back_to_back();
    int t_prev = -1, t_last = -1;
    step(1, 0, 1, 3, 7, 0);
    step(1, 0, 1, 3, 3, 1);
    for (int k = 0; k < 30; k++) begin
      step(1, 0, 0, 0, 0, 0);
      if (o_tick[3]) begin t_prev = t_last; t_last = cyc; end
      checks++;
      if (o_tick !== e_tick || o_sq !== e_sq) begin
        errors++;
        $display("FAIL back_to_back k=%0d tick=%b sq=%b required tick=%b sq=%b", k, o_tick, o_sq, e_tick, e_sq);
      end
    end
    checks++;
    if (t_last - t_prev !== 3) begin
      errors++;
      $display("FAIL back_to_back_period got=%0d required 3", t_last - t_prev);
    end
  endtask

  task automatic test_tc_write();
    int guard = 0;
    while (m_pos[0] != m_n[0] - 1 && guard < 50) begin
      step(1, 0, 0, 0, 0, 0);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL tc_write_search cycles=%0d required <50", guard);
    end
    step(1, 0, 1, 0, 6, 1);
    for (int k = 0; k < 25; k++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (o_tick !== e_tick || o_sq !== e_sq) begin
        errors++;
        $display("FAIL tc_write k=%0d tick=%b sq=%b required tick=%b sq=%b", k, o_tick, o_sq, e_tick, e_sq);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), $urandom_range(0, 1) == 1);
      checks++;
      if (o_tick !== e_tick || o_sq !== e_sq || o_cfg_err !== e_err) begin
        errors++;
        $display("FAIL random k=%0d tick=%b sq=%b err=%b required tick=%b sq=%b err=%b",
                 k, o_tick, o_sq, o_cfg_err, e_tick, e_sq, e_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    step(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 3, 1);
    #2 reset = 0;
    #1;
    model_reset();
    checks++;
    if (o_tick !== 4'b0 || o_sq !== 4'b0 || o_cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid tick=%b sq=%b err=%b required all 0", o_tick, o_sq, o_cfg_err);
    end
    @(negedge clk);
    reset = 1;
    for (int k = 1; k <= 22; k++) begin
      step(1, 0, 0, 0, 0, 0);
      if (first < 0 && o_tick[0]) first = k;
      checks++;
      if (o_tick !== e_tick || o_sq !== e_sq) begin
        errors++;
        $display("FAIL reset_mid_run k=%0d tick=%b sq=%b required tick=%b sq=%b", k, o_tick, o_sq, e_tick, e_sq);
      end
    end
    checks++;
    if (first !== 10) begin
      errors++;
      $display("FAIL reset_mid_first edge=%0d required 10", first);
    end
  endtask

  initial begin
    test_reset();
    test_default_ticks();
    test_reconfig();
    test_cfg_err();
    test_enable_gap();
    test_sync_clr();
    test_back_to_back();
    test_tc_write();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
